// File: rtl/ls_mem_responder_pkg.sv
// Shared types for the load/store memory responder: request record,
// FSM state encoding and data widths.
package ls_pkg;

    localparam int LS_ADDR_W = 25;
    localparam int LS_TAG_W  = 5;
    localparam int LS_DATA_W = 8;
    localparam int WB_DATA_W = 16;

    typedef struct packed {
        logic [LS_ADDR_W-1:0] addr;
        logic [LS_DATA_W-1:0] data;
        logic                 R_nW;
        logic [LS_TAG_W-1:0]  tag;
    } ls_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } ls_state_t;

endpackage

// File: rtl/ls_mem_responder_if.sv
// Bundles the LS request, external memory and writeback channels of the
// responder; slave is the responder side, master the environment side.
interface ls_mem_responder_if
    import ls_pkg::*;
#(
    parameter int ADDR_W = LS_ADDR_W,
    parameter int TAG_W  = LS_TAG_W
);
    logic                 ls_valid;
    logic                 ls_ready;
    logic [ADDR_W-1:0]    ls_addr;
    logic [LS_DATA_W-1:0] ls_data;
    logic                 ls_R_nW;
    logic [TAG_W-1:0]     ls_tag;

    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [LS_DATA_W-1:0] mem_wdata;
    logic                 mem_ack;
    logic [LS_DATA_W-1:0] mem_rdata;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [WB_DATA_W-1:0] wb_data;
    logic [TAG_W-1:0]     wb_tag;

    logic                 busy;
    logic                 spurious_ack;

    modport slave (
        input  ls_valid, ls_addr, ls_data, ls_R_nW, ls_tag,
        input  mem_ack, mem_rdata, wb_ready,
        output ls_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output wb_valid, wb_data, wb_tag, busy, spurious_ack
    );

    modport master (
        output ls_valid, ls_addr, ls_data, ls_R_nW, ls_tag,
        output mem_ack, mem_rdata, wb_ready,
        input  ls_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  wb_valid, wb_data, wb_tag, busy, spurious_ack
    );

endinterface

// File: rtl/ls_mem_responder_fifo.sv
// In-order request queue feeding the responder FSM. Push is refused when
// full, even if a pop happens the same cycle.
module ls_req_fifo
    import ls_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  ls_req_t push_data,
    input  logic    pop,
    output ls_req_t head,
    output logic    full,
    output logic    empty
);
    localparam int PTR_W = $clog2(DEPTH);

    ls_req_t          entry_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = entry_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) entry_q[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ls_mem_responder.sv
// Far end of the Execute load/store port: queues byte requests, runs them on
// the external memory one at a time and returns read bytes with their tag.
//
//   state | meaning
//   IDLE  | waiting; pops the queue head into the issue registers
//   ISSUE | mem_req held with stable address/data until mem_ack
//   RESP  | read result presented on wb_* until wb_ready
module ls_mem_responder
    import ls_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = LS_ADDR_W,
    parameter int TAG_W  = LS_TAG_W
) (
    input logic                clk,
    input logic                rst_n,
    ls_mem_responder_if.slave  bus
);
    ls_state_t            state;
    ls_state_t            state_nx;
    ls_req_t              push_req;
    ls_req_t              head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 load_wb;
    logic                 mem_req;
    logic                 wb_valid;

    logic [ADDR_W-1:0]    iss_addr;
    logic [LS_DATA_W-1:0] iss_data;
    logic                 iss_rnw;
    logic [TAG_W-1:0]     iss_tag;
    logic [WB_DATA_W-1:0] wb_data_q;
    logic [TAG_W-1:0]     wb_tag_q;
    logic                 spur_q;

    assign push_req = '{addr: bus.ls_addr, data: bus.ls_data,
                        R_nW: bus.ls_R_nW, tag: bus.ls_tag};

    assign bus.ls_ready = rst_n && !full;
    assign push         = bus.ls_valid && bus.ls_ready;

    ls_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load_wb  = 1'b0;
        mem_req  = 1'b0;
        wb_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    if (iss_rnw) begin
                        load_wb  = 1'b1;
                        state_nx = RESP;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            RESP: begin
                wb_valid = 1'b1;
                if (bus.wb_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            iss_addr  <= '0;
            iss_data  <= '0;
            iss_rnw   <= 1'b0;
            iss_tag   <= '0;
            wb_data_q <= '0;
            wb_tag_q  <= '0;
            spur_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) begin
                iss_addr <= head.addr;
                iss_data <= head.data;
                iss_rnw  <= head.R_nW;
                iss_tag  <= head.tag;
            end
            if (load_wb) begin
                wb_data_q <= {8'h00, bus.mem_rdata};
                wb_tag_q  <= iss_tag;
            end
            // Any ack not answering an active request is flagged until reset.
            if (bus.mem_ack && state != ISSUE) spur_q <= 1'b1;
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_req && !iss_rnw;
    assign bus.mem_addr     = iss_addr;
    assign bus.mem_wdata    = iss_data;
    assign bus.wb_valid     = wb_valid;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_tag       = wb_tag_q;
    assign bus.busy         = (state != IDLE) || !empty;
    assign bus.spurious_ack = spur_q;

endmodule

// File: tb/tb_ls_mem_responder.sv
// Scoreboard bench for ls_mem_responder: a behavioural memory answers
// requests and a writeback sink checks results against queued expectations.
module tb_ls_mem_responder;
    import ls_pkg::*;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [7:0]  wdata;
    } mem_exp_t;

    typedef struct {
        logic [4:0]  tag;
        logic [15:0] data;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ls_mem_responder_if bus ();

    ls_mem_responder #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_exp_t   exp_mem [$];
    wb_exp_t    exp_wb  [$];
    logic [7:0] rdq     [$];

    int n_vec = 0;
    int n_err = 0;

    int ack_wait   = 0;
    bit ack_hold   = 1'b0;
    bit spur       = 1'b0;
    int req_cycles = 0;
    bit acked_last = 1'b0;

    int          wb_stall = 0;
    bit          wb_seen  = 1'b0;
    logic [15:0] wb_d0;
    logic [4:0]  wb_t0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory model: checks the presented request each cycle, acks after
    // ack_wait extra cycles unless held off.
    always @(negedge clk) begin
        if (acked_last) chk("req_drop_after_ack", bus.mem_req, 0);
        acked_last = 1'b0;
        bus.mem_rdata = 8'h00;
        if (bus.mem_req) begin
            if (exp_mem.size() == 0) begin
                chk("mem_unexpected_req", exp_mem.size(), 1);
                bus.mem_ack = 1'b0;
            end else begin
                chk("mem_we", bus.mem_we, exp_mem[0].we);
                chk("mem_addr", bus.mem_addr, exp_mem[0].addr);
                if (exp_mem[0].we) chk("mem_wdata", bus.mem_wdata, exp_mem[0].wdata);
                req_cycles++;
                if (!ack_hold && req_cycles > ack_wait) begin
                    bus.mem_ack = 1'b1;
                    if (!exp_mem[0].we) begin
                        if (rdq.size() != 0) bus.mem_rdata = rdq.pop_front();
                    end else begin
                        bus.mem_rdata = 8'($urandom);
                    end
                    void'(exp_mem.pop_front());
                    req_cycles = 0;
                    acked_last = 1'b1;
                end else begin
                    bus.mem_ack = 1'b0;
                end
            end
        end else begin
            req_cycles  = 0;
            bus.mem_ack = spur;
        end
    end

    // Writeback sink: optional stall, hold-stability and in-order result check.
    always @(negedge clk) begin
        wb_exp_t e;
        if (bus.wb_valid) begin
            if (!wb_seen) begin
                wb_d0   = bus.wb_data;
                wb_t0   = bus.wb_tag;
                wb_seen = 1'b1;
            end else begin
                chk("wb_data_hold", bus.wb_data, wb_d0);
                chk("wb_tag_hold", bus.wb_tag, wb_t0);
            end
            if (wb_stall > 0) begin
                wb_stall--;
                bus.wb_ready = 1'b0;
                chk("stall_no_issue", bus.mem_req, 0);
            end else begin
                bus.wb_ready = 1'b1;
                if (exp_wb.size() == 0) begin
                    chk("wb_unexpected", exp_wb.size(), 1);
                end else begin
                    e = exp_wb.pop_front();
                    chk("wb_tag", bus.wb_tag, e.tag);
                    chk("wb_data", bus.wb_data, e.data);
                end
                wb_seen = 1'b0;
            end
        end else begin
            bus.wb_ready = 1'b0;
            wb_seen      = 1'b0;
        end
    end

    task automatic push_req(input logic rnw, input logic [24:0] addr, input logic [7:0] d,
                            input logic [4:0] tag, input logic [7:0] rd);
        int guard = 0;
        bus.ls_valid = 1'b1;
        bus.ls_R_nW  = rnw;
        bus.ls_addr  = addr;
        bus.ls_data  = d;
        bus.ls_tag   = tag;
        while (!bus.ls_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ls_ready) begin
            chk("push_timeout", guard, 0);
            bus.ls_valid = 1'b0;
        end else begin
            exp_mem.push_back('{we: ~rnw, addr: addr, wdata: d});
            if (rnw) begin
                rdq.push_back(rd);
                exp_wb.push_back('{tag: tag, data: {8'h00, rd}});
            end
            @(negedge clk);
            bus.ls_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((bus.busy || exp_mem.size() != 0 || exp_wb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_left"}, exp_mem.size() + exp_wb.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ls_ready"}, bus.ls_ready, 0);
        chk({tag, "_mem_req"}, bus.mem_req, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_wb_valid"}, bus.wb_valid, 0);
        chk({tag, "_wb_data"}, bus.wb_data, 0);
        chk({tag, "_wb_tag"}, bus.wb_tag, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_spurious"}, bus.spurious_ack, 0);
    endtask

    initial begin
        bus.ls_valid = 1'b0;
        bus.ls_R_nW  = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_data  = '0;
        bus.ls_tag   = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus.ls_ready, 1);

        // Zero-wait write: single request cycle, no writeback.
        ack_wait = 0;
        push_req(1'b0, 25'h101ABCD, 8'h08, 5'h15, 8'h00);
        drain("write0");

        // Read latency: mem_req after N+1, wb_valid after N+2.
        push_req(1'b1, 25'h0000100, 8'h00, 5'h02, 8'h77);
        chk("lat_req_early", bus.mem_req, 0);
        @(negedge clk);
        chk("lat_req", bus.mem_req, 1);
        @(negedge clk);
        chk("lat_wb_valid", bus.wb_valid, 1);
        drain("read0");

        // Read with three wait states.
        ack_wait = 3;
        push_req(1'b1, 25'h040AFFF, 8'h00, 5'h1F, 8'h13);
        drain("read_wait");
        ack_wait = 0;

        // Fill: one issued plus four queued closes ls_ready.
        ack_hold = 1'b1;
        for (int i = 0; i < 5; i++)
            push_req(1'b1, 25'h0000200 + 25'(i), 8'h00, 5'h08 + 5'(i), 8'(i + 1));
        chk("full_ready", bus.ls_ready, 0);
        chk("full_busy", bus.busy, 1);
        repeat (2) @(negedge clk);
        chk("full_ready_hold", bus.ls_ready, 0);
        ack_hold = 1'b0;
        drain("fill");

        // Writeback stall holds result and blocks the next issue.
        wb_stall = 4;
        push_req(1'b1, 25'h1234567, 8'h00, 5'h0A, 8'hC3);
        push_req(1'b1, 25'h0ABCDEF, 8'h00, 5'h0B, 8'h3C);
        drain("stall");
        chk("stall_consumed", wb_stall, 0);

        // Spurious ack while idle.
        chk("spur_clear", bus.spurious_ack, 0);
        @(posedge clk);
        #1 spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        @(negedge clk);
        chk("spur_set", bus.spurious_ack, 1);
        chk("spur_no_wb", bus.wb_valid, 0);
        repeat (3) @(negedge clk);
        chk("spur_sticky", bus.spurious_ack, 1);
        chk("spur_busy", bus.busy, 0);

        // Reset while ISSUE with two entries queued.
        ack_hold = 1'b1;
        for (int i = 0; i < 3; i++)
            push_req(1'b1, 25'h0000300 + 25'(i), 8'h00, 5'h10 + 5'(i), 8'h50 + 8'(i));
        chk("pre_reset_req", bus.mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        exp_mem.delete();
        exp_wb.delete();
        rdq.delete();
        ack_hold = 1'b0;
        chk_all_zero("midop_reset");
        rst_n = 1'b1;
        @(negedge clk);
        push_req(1'b1, 25'h0000001, 8'h00, 5'h07, 8'hA5);
        drain("post_reset");

        // Mixed write/read traffic back to back.
        for (int i = 0; i < 6; i++)
            push_req(1'(i % 2), 25'($urandom), 8'($urandom), 5'(i + 3), 8'($urandom));
        drain("mixed");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
